// File: rtl/clb_cfg_pkg.sv
// Shared definitions for the CLB configuration loader: FSM state type and
// default geometry of one logic element's configuration memory.
package clb_cfg_pkg;

  localparam int unsigned CFG_ADDR_W   = 5;
  localparam int unsigned CFG_NUM_BITS = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2
  } cfg_state_t;

endpackage

// File: rtl/cfg_word_shifter.sv
// Holds one bitstream word and shifts it out LSB first; bit 0 is the bit
// currently presented to the memory bank.
module cfg_word_shifter #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  output logic              bit0
);

  logic [DATA_W-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift) begin
      sr_q <= sr_q >> 1;
    end
  end

  assign bit0 = sr_q[0];

endmodule

// File: rtl/clb_cfg_bank_loader.sv
// Serialises a word-wide configuration bitstream into one-bit writes to the
// fle memory bank, one bit per cycle, and flags completion.
module clb_cfg_bank_loader
  import clb_cfg_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = CFG_ADDR_W,
  parameter int unsigned NUM_BITS = CFG_NUM_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              enable,
  output logic [0:ADDR_W-1] address,
  output logic              data_in,
  output logic              cfg_busy,
  output logic              cfg_done
);

  // One spare bit so idx never wraps when NUM_BITS fills the whole bank.
  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  cfg_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ready_q, ready_d;
  logic              enable_q, enable_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [31:0]       remain;
  logic [CNT_W-1:0]  cnt_load;
  logic              last_bit;
  logic              sh_load, sh_shift, sh_clear;
  logic              sh_bit0;

  assign remain   = NUM_BITS - 32'(idx_q);
  assign cnt_load = (remain > DATA_W) ? CNT_W'(DATA_W) : CNT_W'(remain);
  assign last_bit = (32'(idx_q) + 32'd1) == NUM_BITS;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          idx_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      LOAD: begin
        if (cfg_valid) begin
          state_d = WRITE;
          cnt_d   = cnt_load;
          sh_load = 1'b1;
        end
      end
      WRITE: begin
        idx_d = idx_q + 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          // Clearing drops any discarded upper bits so data_in idles at 0.
          sh_clear = 1'b1;
          if (last_bit) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else begin
          sh_shift = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    ready_d  = (state_d == LOAD);
    enable_d = (state_d == WRITE);
    addr_d   = enable_d ? idx_d[ADDR_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      ready_q  <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      ready_q  <= ready_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  cfg_word_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .shift (sh_shift),
    .clear (sh_clear),
    .din   (cfg_data),
    .bit0  (sh_bit0)
  );

  assign cfg_ready = ready_q;
  assign enable    = enable_q;
  assign address   = addr_q;
  assign data_in   = sh_bit0;
  assign cfg_busy  = busy_q;
  assign cfg_done  = done_q;

endmodule

// File: tb/tb_clb_cfg_bank_loader.sv
// Bench for clb_cfg_bank_loader: a bit-queue model checked every cycle on the
// default instance, plus literal checks on both default and 32-bit instances.
module tb_clb_cfg_bank_loader;

  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 5;
  localparam int unsigned NB   = 17;
  localparam int unsigned NB_B = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  logic          cfg_start = 1'b0, cfg_valid = 1'b0;
  logic [DW-1:0] cfg_data = '0;
  logic          cfg_ready, enable, data_in, cfg_busy, cfg_done;
  logic [0:AW-1] address;

  logic          b_start = 1'b0, b_valid = 1'b0;
  logic [DW-1:0] b_data = '0;
  logic          b_ready, b_enable, b_data_in, b_busy, b_done;
  logic [0:AW-1] b_address;

  clb_cfg_bank_loader #(.DATA_W(DW), .ADDR_W(AW), .NUM_BITS(NB)) u_dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .enable(enable), .address(address),
    .data_in(data_in), .cfg_busy(cfg_busy), .cfg_done(cfg_done)
  );

  clb_cfg_bank_loader #(.DATA_W(DW), .ADDR_W(AW), .NUM_BITS(NB_B)) u_dut_b (
    .clk(clk), .reset(reset), .cfg_start(b_start), .cfg_data(b_data),
    .cfg_valid(b_valid), .cfg_ready(b_ready), .enable(b_enable), .address(b_address),
    .data_in(b_data_in), .cfg_busy(b_busy), .cfg_done(b_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: pending bits of the current word, bits written so far, and the
  // expected value of every output in the current cycle.
  bit        m_q[$];
  int        m_written = 0;
  int        m_n;
  logic      e_ready = 1'b0, e_enable = 1'b0, e_data = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  logic [4:0] e_addr = '0;
  bit        chk_on = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_written = 0;
      {e_ready, e_enable, e_addr, e_data, e_busy, e_done} = '0;
    end else begin
      if (e_enable) begin
        void'(m_q.pop_front());
        m_written++;
      end
      if (e_ready && cfg_valid) begin
        m_n = NB - m_written;
        if (m_n > DW) m_n = DW;
        for (int i = 0; i < m_n; i++) m_q.push_back(cfg_data[i]);
      end
      if (!e_busy && cfg_start) begin
        e_busy    = 1'b1;
        e_done    = 1'b0;
        m_written = 0;
        m_q.delete();
      end else if (e_busy && m_q.size() == 0 && m_written == NB) begin
        e_busy = 1'b0;
        e_done = 1'b1;
      end
      e_enable = (m_q.size() != 0);
      e_addr   = e_enable ? 5'(m_written) : 5'd0;
      e_data   = e_enable ? m_q[0] : 1'b0;
      e_ready  = e_busy && !e_enable;
    end
  end

  logic [9:0] cmp_got, cmp_exp;
  always @(negedge clk) begin
    if (chk_on) begin
      cmp_got = {cfg_ready, enable, address, data_in, cfg_busy, cfg_done};
      cmp_exp = {e_ready, e_enable, e_addr, e_data, e_busy, e_done};
      n_vec++;
      if (cmp_got !== cmp_exp) begin
        n_bad++;
        $display("FAIL cycle %0d outputs {ready,en,addr,data,busy,done}: got %b, expected %b",
                 cyc, cmp_got, cmp_exp);
      end
    end
  end

  // Write/done logs for literal checks.
  int   a_wa[$], a_wd[$], a_wc[$];
  int   a_done_cyc = -1;
  logic a_done_prev = 1'b0;
  always @(negedge clk) begin
    if (enable === 1'b1) begin
      a_wa.push_back(int'(address));
      a_wd.push_back(int'(data_in));
      a_wc.push_back(cyc);
    end
    if (cfg_done === 1'b1 && a_done_prev !== 1'b1 && a_done_cyc < 0) a_done_cyc = cyc;
    a_done_prev = cfg_done;
  end

  int   b_wa[$], b_wd[$];
  int   b_done_cyc = -1;
  logic b_done_prev = 1'b0;
  always @(negedge clk) begin
    if (b_enable === 1'b1) begin
      b_wa.push_back(int'(b_address));
      b_wd.push_back(int'(b_data_in));
    end
    if (b_done === 1'b1 && b_done_prev !== 1'b1 && b_done_cyc < 0) b_done_cyc = cyc;
    b_done_prev = b_done;
  end

  // Word feeders: advance to the next word after each accepted handshake.
  logic [DW-1:0] a_words[4];
  int            a_acc = 0;
  always @(posedge clk) begin
    if (cfg_valid === 1'b1 && cfg_ready === 1'b1) begin
      a_acc++;
      #1 cfg_data = (a_acc < 4) ? a_words[a_acc[1:0]] : '0;
    end
  end

  logic [DW-1:0] b_words[4];
  int            b_acc = 0;
  always @(posedge clk) begin
    if (b_valid === 1'b1 && b_ready === 1'b1) begin
      b_acc++;
      #1 b_data = (b_acc < 4) ? b_words[b_acc[1:0]] : '0;
    end
  end

  task automatic start_a(input logic [DW-1:0] w0, w1, w2, output int t);
    a_words[0] = w0;
    a_words[1] = w1;
    a_words[2] = w2;
    a_words[3] = '0;
    a_acc      = 0;
    cfg_data   = w0;
    a_wa.delete();
    a_wd.delete();
    a_wc.delete();
    a_done_cyc = -1;
    cfg_start  = 1'b1;
    cfg_valid  = 1'b1;
    t          = cyc;
    step();
    cfg_start  = 1'b0;
  endtask

  task automatic wait_done_a();
    for (int k = 0; k < 80 && a_done_cyc < 0; k++) step();
    cfg_valid = 1'b0;
  endtask

  task automatic check_load_a(input string tag, input int t, input int done_lat);
    int bad;
    bad = -1;
    check({tag, "_writes"}, a_wa.size(), 17);
    for (int i = 0; i < a_wa.size(); i++) if (bad < 0 && a_wa[i] != i) bad = i;
    check({tag, "_addr_seq_first_bad"}, bad, -1);
    check({tag, "_done_cycle"}, (a_done_cyc < 0) ? -1 : a_done_cyc - t, done_lat);
  endtask

  int t;
  int mx;
  int bad;
  bit exp_nom[17] = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 1, 1, 0, 0, 1};
  logic [31:0] b_bits;

  initial begin
    step();
    chk_on = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Nominal load.
    start_a(8'hA5, 8'h3C, 8'h01, t);
    @(negedge clk);
    check("nom_ready_at_T+1", int'(cfg_ready), 1);
    wait_done_a();
    check_load_a("nom", t, 21);
    check("nom_first_enable", (a_wc.size() > 0) ? a_wc[0] - t : -1, 2);
    check("nom_last_enable", (a_wc.size() > 0) ? a_wc[a_wc.size()-1] - t : -1, 20);
    for (int i = 0; i < 17; i++)
      check($sformatf("nom_data_%0d", i), (i < a_wd.size()) ? a_wd[i] : -1, int'(exp_nom[i]));
    repeat (2) step();

    // Last-word truncation.
    start_a(8'hA5, 8'h3C, 8'hFF, t);
    wait_done_a();
    check_load_a("trunc", t, 21);
    check("trunc_addr16_data", (a_wd.size() > 16) ? a_wd[16] : -1, 1);
    check("trunc_words_accepted", a_acc, 3);
    mx = -1;
    foreach (a_wa[i]) if (a_wa[i] > mx) mx = a_wa[i];
    check("trunc_max_addr", mx, 16);
    repeat (2) step();

    // Backpressure: five stalled LOAD cycles before the second word.
    start_a(8'hA5, 8'h3C, 8'h01, t);
    step();
    cfg_valid = 1'b0;
    repeat (8) step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready_held", int'(cfg_ready), 1);
      check("bp_enable_low", int'(enable), 0);
      step();
    end
    cfg_valid = 1'b1;
    wait_done_a();
    check_load_a("bp", t, 26);
    repeat (2) step();

    // Start pulse during the first word's writes is ignored.
    start_a(8'hA5, 8'h3C, 8'h01, t);
    repeat (3) step();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    wait_done_a();
    check_load_a("busy_start", t, 21);
    repeat (2) step();

    // Reset after the 10th write, then a fresh load.
    start_a(8'hA5, 8'h3C, 8'h01, t);
    for (int k = 0; k < 40 && a_wa.size() < 10; k++) step();
    reset     = 1'b1;
    cfg_valid = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", int'(cfg_ready), 0);
    check("rst_enable", int'(enable), 0);
    check("rst_address", int'(address), 0);
    check("rst_data_in", int'(data_in), 0);
    check("rst_busy", int'(cfg_busy), 0);
    check("rst_done", int'(cfg_done), 0);
    step();
    start_a(8'h5A, 8'hC3, 8'h00, t);
    wait_done_a();
    check_load_a("after_rst", t, 21);
    repeat (2) step();

    // Full bank: 32 bits from four words; 36 busy cycles, done the cycle after.
    b_words[0] = 8'h12;
    b_words[1] = 8'h34;
    b_words[2] = 8'h56;
    b_words[3] = 8'h78;
    b_bits     = 32'h7856_3412;
    b_acc      = 0;
    b_data     = b_words[0];
    b_start    = 1'b1;
    b_valid    = 1'b1;
    t          = cyc;
    step();
    b_start = 1'b0;
    for (int k = 0; k < 100 && b_done_cyc < 0; k++) step();
    b_valid = 1'b0;
    check("full_writes", b_wa.size(), 32);
    check("full_words_accepted", b_acc, 4);
    bad = -1;
    for (int i = 0; i < b_wa.size(); i++) if (bad < 0 && b_wa[i] != i) bad = i;
    check("full_addr_seq_first_bad", bad, -1);
    bad = -1;
    for (int i = 0; i < b_wd.size() && i < 32; i++)
      if (bad < 0 && b_wd[i] != int'(b_bits[i])) bad = i;
    check("full_data_first_bad", bad, -1);
    check("full_done_cycle", (b_done_cyc < 0) ? -1 : b_done_cyc - t, 37);
    step();
    @(negedge clk);
    check("full_idle_busy", int'(b_busy), 0);
    check("full_idle_enable", int'(b_enable), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
